// File: rtl/vtx_bank_ctrl.sv
// vtx_bank_ctrl: double-buffered vertex bank with 2-requester write arbiter and frame-synchronous swap
module vtx_bank_ctrl #(
    parameter int W    = 21,
    parameter int NVTX = 4
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [1:0]          req0_idx,
    input  logic signed [W-1:0] req0_x,
    input  logic signed [W-1:0] req0_y,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [1:0]          req1_idx,
    input  logic signed [W-1:0] req1_x,
    input  logic signed [W-1:0] req1_y,
    input  logic                commit,
    output logic                armed,
    output logic                swap_done,
    output logic [NVTX-1:0]     vtx_valid,
    output logic signed [W-1:0] vtx1_X,
    output logic signed [W-1:0] vtx1_Y,
    output logic signed [W-1:0] vtx2_X,
    output logic signed [W-1:0] vtx2_Y,
    output logic signed [W-1:0] vtx3_X,
    output logic signed [W-1:0] vtx3_Y,
    output logic signed [W-1:0] vtx4_X,
    output logic signed [W-1:0] vtx4_Y
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
    state_t state, state_nxt;
    logic last_grant, idle, wr;
    logic [1:0] widx;
    logic signed [W-1:0] wx, wy;
    logic signed [W-1:0] sx [NVTX];
    logic signed [W-1:0] sy [NVTX];
    logic signed [W-1:0] ax [NVTX];
    logic signed [W-1:0] ay [NVTX];
    logic [NVTX-1:0] smask;

    // Contention goes to whichever requester was not granted last; writes only while idle
    always_comb begin
        idle = state == IDLE;
        req0_ready = idle & req0_valid & (~req1_valid | last_grant);
        req1_ready = idle & req1_valid & (~req0_valid | ~last_grant);
        wr = req0_ready | req1_ready;
        widx = req0_ready ? req0_idx : req1_idx;
        wx = req0_ready ? req0_x : req1_x;
        wy = req0_ready ? req0_y : req1_y;
        armed = state == ARMED;
        swap_done = state == DONE;
        state_nxt = idle ? (commit ? ARMED : IDLE) : (armed ? (frame_start ? DONE : ARMED) : IDLE);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            sx <= '{default: '0};
            sy <= '{default: '0};
            ax <= '{default: '0};
            ay <= '{default: '0};
            smask <= '0;
            vtx_valid <= '0;
        end else begin
            if (wr) begin
                sx[widx] <= wx;
                sy[widx] <= wy;
                smask[widx] <= 1'b1;
                last_grant <= req1_ready;
            end
            if (armed && frame_start) begin
                ax <= sx;
                ay <= sy;
                vtx_valid <= smask;
            end
        end
    end

    assign vtx1_X = ax[0];
    assign vtx1_Y = ay[0];
    assign vtx2_X = ax[1];
    assign vtx2_Y = ay[1];
    assign vtx3_X = ax[2];
    assign vtx3_Y = ay[2];
    assign vtx4_X = ax[3];
    assign vtx4_Y = ay[3];
endmodule
